axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

AXI4-Lite initiator that converts a single-outstanding command/response port into AXI4-Lite read and write transactions. It sits between a local controller, such as a DMA-lite engine or a bridge from the core's data bus, and any AXI4-Lite responder in the SoC, including the peripheral register interfaces. One transaction is in flight at a time. The responder's BRESP/RRESP is returned to the requester unchanged.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: watchdog limit in aclk cycles. Used only when AXI_LITE_CMD_MASTER_TIMEOUT_EN is defined. Minimum 2.

Ports:
- aclk  in  1  the only clock.
- aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address, forwarded unchanged.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout.
- m_axi_awaddr / m_axi_awvalid / m_axi_awready  out/out/in  32/1/1  write address channel.
- m_axi_wdata / m_axi_wvalid / m_axi_wready  out/out/in  32/1/1  write data channel; strobe is implicitly all ones.
- m_axi_bresp / m_axi_bvalid / m_axi_bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr / m_axi_arvalid / m_axi_arready  out/out/in  32/1/1  read address channel.
- m_axi_rdata / m_axi_rresp / m_axi_rvalid / m_axi_rready  in/in/in/out  32/2/1/1  read data channel.

## Operation
- All outputs are registered except cmd_ready, which is (state==IDLE).
- Reset values:
  - all *valid outputs, bready, rready: 0.
  - awaddr, wdata, araddr, rsp_rdata: 0.
  - rsp_resp: 2'b00. rsp_write: 0.
  - cmd_ready: 1.
- States and transitions:
  - IDLE: a cmd handshake latches addr/data/write.
    - A write goes to WR_REQ with awvalid=1 and wvalid=1.
    - A read goes to RD_REQ with arvalid=1.
  - WR_REQ: awvalid and wvalid are cleared independently at their own handshakes, in either order or together.
    - Once both are done, set bready=1 and go to WR_RSP.
    - bready is never high before both handshakes complete.
  - WR_RSP: on bvalid, capture bresp, clear bready, set rsp_valid, go to RSP.
  - RD_REQ: on arready, clear arvalid, set rready=1, go to RD_RSP.
  - RD_RSP: on rvalid, capture rdata/rresp, clear rready, set rsp_valid, go to RSP.
  - RSP: hold rsp_* stable until rsp_ready, then clear rsp_valid and return to IDLE.
- The address and data outputs stay stable while their valid is high. Per AXI, a valid is never dropped before its ready.
- SLVERR/DECERR from the responder is passed through as-is; it is not retried.
- When aresetn is asserted mid-transaction, all state is discarded asynchronously. The responder must be in the same reset domain.

## Timing
- Command-to-AXI: the valids go high in the cycle after the cmd handshake.
- Zero-wait-state responder:
  - Write: cmd handshake at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: same timing, with AR at cycle 1 and R at cycle 2.
- The next cmd can be accepted in the cycle after the rsp handshake, giving a minimum of 4 cycles per transaction.
- rsp_ready already high when rsp_valid rises completes the handoff in that same cycle.

## Configuration
- AXI_LITE_CMD_MASTER_TIMEOUT_EN defined:
  - A counter starts on entry to WR_REQ/RD_REQ. If it reaches TIMEOUT_CYCLES before the response handshake, the block sets rsp_valid with rsp_resp=2'b11 and rsp_rdata=0.
  - Outstanding valids stay high until their handshakes.
  - The FSM then goes to DRAIN, keeping bready/rready high (bready only after AW and W complete). It absorbs and discards the late response, then returns to IDLE once the rsp handshake has also completed.
  - cmd_ready stays 0 throughout DRAIN.
- Macro undefined: no counter and no DRAIN state. The block waits indefinitely.

## Structure
- Package axi_lite_pkg holds:
  - response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the state encoding localparams.
- One natural sub-module, axi_lite_wdt, a load/clear/expire counter instantiated only under the macro.

## Test plan
- Write 0x1234_5678 to 0x10 with zero-wait AW/W/B: AW and W handshakes at cycle 1, rsp_valid at cycle 3, rsp_resp=00, rsp_rdata=0.
- Read 0x10 with arready delayed 3 cycles and rvalid carrying 0xCAFE_F00D/RRESP=10: araddr stays stable, rsp_rdata=0xCAFEF00D, rsp_resp=10.
- Write with wready at cycle 1 and awready at cycle 4: wvalid drops at cycle 2, bready rises only after the AW handshake, completion is correct.
- rsp_ready held low 5 cycles with cmd_valid high: cmd_ready stays 0 and rsp fields are stable; the next command is accepted 1 cycle after the rsp handshake.
- With the macro defined and TIMEOUT_CYCLES=8, a read whose responder never asserts rvalid: rsp_resp=11 at cycle 9 after AR. A late rvalid is then absorbed with rready=1, after which cmd_ready=1.
- aresetn pulsed low mid-WR_REQ: all valids drop immediately, cmd_ready=1 after release, and a subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite command master: response codes and
// FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // Locally generated code returned when the watchdog fires.
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR_REQ = 3'd1;
  localparam logic [2:0] ST_WR_RSP = 3'd2;
  localparam logic [2:0] ST_RD_REQ = 3'd3;
  localparam logic [2:0] ST_RD_RSP = 3'd4;
  localparam logic [2:0] ST_RSP    = 3'd5;
  localparam logic [2:0] ST_DRAIN  = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    WR_REQ = ST_WR_REQ,
    WR_RSP = ST_WR_RSP,
    RD_REQ = ST_RD_REQ,
    RD_RSP = ST_RD_RSP,
    RSP    = ST_RSP,
    DRAIN  = ST_DRAIN
  } state_e;

endpackage

// File: rtl/axi_lite_wdt.sv
// Watchdog counter: load arms and zeroes it, clr disarms it, expire is high
// in the cycle the armed count reaches LIMIT-1 (i.e. LIMIT cycles after load).
module axi_lite_wdt #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // Next count: load wins over clear; count only while armed.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (clr) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expire = armed_q && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding command/response port to AXI4-Lite initiator.
// Optional watchdog with DRAIN recovery: define AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_q, state_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bready_q, bready_d, rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic        aw_pend, w_pend, resp_hs;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  logic drain_done_q, drain_done_d;
  logic wdt_expire;

  axi_lite_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
    .clk    (aclk),
    .rst_n  (aresetn),
    .load   (state_q == IDLE && cmd_valid),
    .clr    (resp_hs || wdt_expire),
    .expire (wdt_expire)
  );
`endif

  // AW/W still outstanding after this cycle's handshakes.
  assign aw_pend = awvalid_q && !m_axi_awready;
  assign w_pend  = wvalid_q && !m_axi_wready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    resp_hs     = 1'b0;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    drain_done_d = drain_done_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          bready_d = 1'b1;
          state_d  = WR_RSP;
        end
      end
      WR_RSP: begin
        if (m_axi_bvalid) begin
          resp_hs     = 1'b1;
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RSP;
        end
      end
      RD_RSP: begin
        if (m_axi_rvalid) begin
          resp_hs     = 1'b1;
          rready_d    = 1'b0;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
      // Finish the abandoned AXI transaction and discard its response.
      DRAIN: begin
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (rsp_write_q) begin
          awvalid_d = aw_pend;
          wvalid_d  = w_pend;
          if (bready_q && m_axi_bvalid) begin
            bready_d     = 1'b0;
            drain_done_d = 1'b1;
          end else if (!drain_done_q && !aw_pend && !w_pend) begin
            bready_d = 1'b1;
          end
        end else begin
          if (arvalid_q && m_axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end
          if (rready_q && m_axi_rvalid) begin
            rready_d     = 1'b0;
            drain_done_d = 1'b1;
          end
        end
        if (drain_done_d && !rsp_valid_d) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    // A real response arriving in the expiry cycle takes precedence.
    if (wdt_expire && !resp_hs) begin
      rsp_valid_d  = 1'b1;
      rsp_resp_d   = RESP_TIMEOUT;
      rsp_rdata_d  = '0;
      drain_done_d = 1'b0;
      state_d      = DRAIN;
    end
`endif
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  // Tracks whether the late response has been absorbed in DRAIN.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) drain_done_q <= 1'b0;
    else          drain_done_q <= drain_done_d;
  end
`endif

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: cycle-accurate responder driven from scenario
// tasks, with a response scoreboard checked at every rsp handshake.
module tb_axi_lite_cmd_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  always #5 aclk = ~aclk;

  axi_lite_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  // Scoreboard consumer: every rsp handshake must match the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rsp write=%b rdata=%h resp=%b", rsp_write, rsp_rdata, rsp_resp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_write !== e.w || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
          errors++;
          $display("FAIL sb_rsp got w=%b rdata=%h resp=%b want w=%b rdata=%h resp=%b",
                   rsp_write, rsp_rdata, rsp_resp, e.w, e.rdata, e.resp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    repeat (3) tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_valids got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    checks++;
    if ({awaddr, wdata, araddr, rsp_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", awaddr, wdata, araddr, rsp_rdata);
    end
    checks++;
    if ({rsp_resp, rsp_write} !== 3'b000) begin errors++; $display("FAIL reset_rsp got %b want 000", {rsp_resp, rsp_write}); end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h1234_5678;
    awready = 1; wready = 1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr0_cmd_ready got %b want 1", cmd_ready); end
    sb.push_back('{1'b1, 32'h0, 2'b00});
    tick(); // cycle 1
    cmd_valid = 0;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b110 || awaddr !== 32'h10 || wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL wr0_c1 got aw/w/b=%b addr=%h data=%h want 110 10 12345678", {awvalid, wvalid, bready}, awaddr, wdata);
    end
    tick(); // cycle 2
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr0_c2 got aw/w/b=%b want 001", {awvalid, wvalid, bready}); end
    bvalid = 1; bresp = 2'b00;
    tick(); // cycle 3
    bvalid = 0; awready = 0; wready = 0;
    checks++;
    if ({rsp_valid, bready} !== 2'b10) begin errors++; $display("FAIL wr0_c3 got rsp_valid/bready=%b want 10", {rsp_valid, bready}); end
    tick(); // cycle 4
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL wr0_c4 got rsp_valid/cmd_ready=%b want 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read_delayed();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
    sb.push_back('{1'b0, 32'hCAFE_F00D, 2'b10});
    tick();
    cmd_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h10 || rready !== 1'b0) begin
        errors++; $display("FAIL rd_wait_c%0d got arvalid=%b araddr=%h rready=%b want 1 10 0", c, arvalid, araddr, rready);
      end
      tick();
    end
    arready = 1; // cycle 4
    tick();
    arready = 0;
    checks++;
    if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL rd_c5 got arvalid/rready=%b want 01", {arvalid, rready}); end
    rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
    tick();
    rvalid = 0; rdata = 0; rresp = 0;
    checks++;
    if ({rsp_valid, rready} !== 2'b10) begin errors++; $display("FAIL rd_c6 got rsp_valid/rready=%b want 10", {rsp_valid, rready}); end
    tick();
  endtask

  task automatic test_split_write();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 32'h0, 2'b10});
    tick(); // cycle 1
    cmd_valid = 0; wready = 1;
    tick(); // cycle 2
    wready = 0;
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h40) begin
        errors++; $display("FAIL split_c%0d got aw/w/b=%b addr=%h want 100 40", c, {awvalid, wvalid, bready}, awaddr);
      end
      if (c == 4) awready = 1;
      tick();
    end
    awready = 0; // cycle 5
    checks++;
    if ({awvalid, bready} !== 2'b01) begin errors++; $display("FAIL split_c5 got aw/b=%b want 01", {awvalid, bready}); end
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0; bresp = 0;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL split_c6 got rsp_valid=%b want 1", rsp_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h80;
    sb.push_back('{1'b0, 32'h1357_9BDF, 2'b00});
    tick(); // cycle 1
    cmd_valid = 0; arready = 1;
    tick(); // cycle 2
    arready = 0; rvalid = 1; rdata = 32'h1357_9BDF; rresp = 2'b00;
    tick(); // cycle 3
    rvalid = 0; rdata = 0;
    rsp_ready = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A5_A5A5;
    for (int c = 3; c <= 7; c++) begin
      checks++;
      if ({rsp_valid, cmd_ready, rsp_write} !== 3'b100 || rsp_rdata !== 32'h1357_9BDF || rsp_resp !== 2'b00) begin
        errors++; $display("FAIL bp_stall_c%0d got v/cr/w=%b rdata=%h resp=%b want 100 13579bdf 00",
                           c, {rsp_valid, cmd_ready, rsp_write}, rsp_rdata, rsp_resp);
      end
      tick();
    end
    rsp_ready = 1; // cycle 8: handshake
    sb.push_back('{1'b1, 32'h0, 2'b01});
    tick(); // cycle 9
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL bp_c9 got cmd_ready/rsp_valid=%b want 10", {cmd_ready, rsp_valid}); end
    awready = 1; wready = 1;
    tick(); // cycle 10
    cmd_valid = 0;
    checks++;
    if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h20 || wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL bp_c10 got aw/w=%b addr=%h data=%h want 11 20 a5a5a5a5", {awvalid, wvalid}, awaddr, wdata);
    end
    tick(); // cycle 11
    awready = 0; wready = 0;
    bvalid = 1; bresp = 2'b01;
    tick(); // cycle 12
    bvalid = 0; bresp = 0;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_c12 got rsp_valid=%b want 1", rsp_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h1111_1111;
    tick(); // cycle 1
    cmd_valid = 0;
    checks++;
    if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got aw/w=%b want 11", {awvalid, wvalid}); end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL rstmid_drop got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    tick();
    aresetn = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got %b want 1", cmd_ready); end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h44;
    sb.push_back('{1'b0, 32'h0BAD_BEEF, 2'b00});
    tick();
    cmd_valid = 0; arready = 1;
    tick();
    arready = 0;
    checks++;
    if (rready !== 1'b1) begin errors++; $display("FAIL rstmid_rready got %b want 1", rready); end
    rvalid = 1; rdata = 32'h0BAD_BEEF; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 0;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_rsp got rsp_valid=%b want 1", rsp_valid); end
    tick();
  endtask

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50;
    sb.push_back('{1'b0, 32'h0, 2'b11});
    tick(); // cycle 1
    cmd_valid = 0; arready = 1;
    tick(); // cycle 2
    arready = 0;
    for (int c = 2; c <= 8; c++) begin
      checks++;
      if ({rsp_valid, rready} !== 2'b01) begin errors++; $display("FAIL tmo_wait_c%0d got v/rready=%b want 01", c, {rsp_valid, rready}); end
      tick();
    end
    checks++; // cycle 9
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11) begin errors++; $display("FAIL tmo_c9 got v=%b resp=%b want 1 11", rsp_valid, rsp_resp); end
    tick(); // cycle 10
    checks++;
    if ({rsp_valid, cmd_ready, rready} !== 3'b001) begin errors++; $display("FAIL tmo_drain got v/cr/rr=%b want 001", {rsp_valid, cmd_ready, rready}); end
    rvalid = 1; rdata = 32'hFFFF_FFFF;
    tick(); // cycle 11
    rvalid = 0; rdata = 0;
    checks++;
    if ({cmd_ready, rready, rsp_valid} !== 3'b100) begin errors++; $display("FAIL tmo_done got cr/rr/v=%b want 100", {cmd_ready, rready, rsp_valid}); end
  endtask
`else
  task automatic test_no_timeout();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50;
    sb.push_back('{1'b0, 32'h600D_F00D, 2'b00});
    tick();
    cmd_valid = 0; arready = 1;
    tick();
    arready = 0;
    for (int c = 2; c <= 21; c++) begin
      checks++;
      if ({rsp_valid, rready, cmd_ready} !== 3'b010) begin
        errors++; $display("FAIL notmo_wait_c%0d got v/rr/cr=%b want 010", c, {rsp_valid, rready, cmd_ready});
      end
      tick();
    end
    rvalid = 1; rdata = 32'h600D_F00D; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 0;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL notmo_rsp got rsp_valid=%b want 1", rsp_valid); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_delayed();
    test_split_write();
    test_back_to_back();
    test_reset_mid();
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
